// File: rtl/la_spi_pkg.sv
// Shared types and helpers for the SPI command master.
//   spi_state_t : FSM state encoding
//   TICK_W      : width of the phase tick counter (covers CLK_DIV up to 255)
//   eff_len     : maps a requested bit count to the count actually sent
//                 (0 and anything above max_bits both mean max_bits)
package la_spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        HOLD,
        GAP
    } spi_state_t;

    localparam int TICK_W = 8;

    function automatic int unsigned eff_len(input int unsigned len,
                                            input int unsigned max_bits);
        if (len == 0 || len > max_bits) begin
            return max_bits;
        end
        return len;
    endfunction

endpackage

// File: rtl/la_spi_cmd_master_tick.sv
// Restartable phase timer for the SPI command master.
// Loads CLK_DIV-1 on i_restart and counts down to zero, holding there;
// o_tick is high in the last cycle of a CLK_DIV-cycle phase.
// Ports:
//   wb_clk_i  in  clock
//   wb_rst_i  in  synchronous active-high reset
//   i_restart in  reload the counter (asserted on every FSM state change)
//   o_tick    out current phase ends this cycle
module spi_tick_gen
    import la_spi_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic i_restart,
    output logic o_tick
);

    localparam logic [TICK_W-1:0] LP_LOAD = TICK_W'(CLK_DIV - 1);

    logic [TICK_W-1:0] r_cnt;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_cnt <= '0;
        end else if (i_restart) begin
            r_cnt <= LP_LOAD;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - TICK_W'(1);
        end
    end

    assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/la_spi_cmd_master.sv
// Write-only SPI initiator (mode 0, MSB first) that serialises a parallel
// command word onto csb/sclk/mosi.
// Ports:
//   wb_clk_i  in   clock
//   wb_rst_i  in   synchronous active-high reset; aborts any transfer
//   i_valid   in   request strobe, taken when i_valid & o_ready
//   o_ready   out  idle and able to accept a request
//   i_data    in   right-aligned word, bit [len-1] goes out first
//   i_len     in   bit count; 0 or >MAX_BITS sends MAX_BITS bits
//   o_csb     out  chip select, active low
//   o_sclk    out  serial clock, idles low
//   o_mosi    out  serial data, changes only with sclk low
//   o_busy    out  inverse of o_ready
//   o_done    out  one-cycle pulse when a word completes
//
// state | meaning
// IDLE  | ready, bus idle, waiting for a request
// SETUP | csb low, first bit on mosi, sclk low
// HIGH  | sclk high, slave samples mosi
// LOW   | sclk low, next bit presented
// HOLD  | sclk low after the last bit, csb still low
// GAP   | csb high before ready returns; done pulses on entry
module la_spi_cmd_master
    import la_spi_pkg::*;
#(
    parameter int MAX_BITS = 32,
    parameter int LEN_W    = 6,
    parameter int CLK_DIV  = 2
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [MAX_BITS-1:0] i_data,
    input  logic [LEN_W-1:0]    i_len,
    output logic                o_csb,
    output logic                o_sclk,
    output logic                o_mosi,
    output logic                o_busy,
    output logic                o_done
);

    spi_state_t          r_state;
    spi_state_t          w_next_state;
    logic [MAX_BITS-1:0] r_shift;
    logic [MAX_BITS-1:0] w_shift_nxt;
    logic [LEN_W-1:0]    r_bitcnt;
    logic [LEN_W-1:0]    w_bitcnt_nxt;
    logic [LEN_W-1:0]    w_len;
    logic [LEN_W-1:0]    w_align;
    logic                w_tick;
    logic                w_restart;
    logic                w_accept;
    logic                w_csb;
    logic                w_sclk;
    logic                w_mosi;
    logic                w_ready;
    logic                w_done;
    logic                r_csb;
    logic                r_sclk;
    logic                r_mosi;
    logic                r_ready;
    logic                r_busy;
    logic                r_done;

    assign w_len     = LEN_W'(eff_len(32'(i_len), unsigned'(MAX_BITS)));
    // Left-justify the word so the first bit to send always sits at the MSB.
    assign w_align   = LEN_W'(MAX_BITS) - w_len;
    assign w_accept  = i_valid & r_ready;
    assign w_restart = (w_next_state != r_state);

    spi_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .i_restart (w_restart),
        .o_tick    (w_tick)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Outputs are decoded from the next state and registered, so they change
    // on the same edge as the state they describe.
    always_comb begin
        w_next_state = r_state;
        w_shift_nxt  = r_shift;
        w_bitcnt_nxt = r_bitcnt;
        w_csb        = 1'b1;
        w_sclk       = 1'b0;
        w_mosi       = 1'b0;
        w_ready      = 1'b0;
        w_done       = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = SETUP;
                    w_shift_nxt  = i_data << w_align;
                    w_bitcnt_nxt = w_len;
                end
            end
            SETUP: if (w_tick) w_next_state = HIGH;
            HIGH: begin
                if (w_tick) begin
                    if (r_bitcnt == LEN_W'(1)) begin
                        w_next_state = HOLD;
                    end else begin
                        w_next_state = LOW;
                        w_shift_nxt  = r_shift << 1;
                        w_bitcnt_nxt = r_bitcnt - LEN_W'(1);
                    end
                end
            end
            LOW:  if (w_tick) w_next_state = HIGH;
            HOLD: if (w_tick) w_next_state = GAP;
            GAP:  if (w_tick) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase

        case (w_next_state)
            IDLE: w_ready = 1'b1;
            SETUP, HIGH, LOW, HOLD: begin
                w_csb  = 1'b0;
                w_sclk = (w_next_state == HIGH);
                w_mosi = w_shift_nxt[MAX_BITS-1];
            end
            GAP: w_done = (r_state != GAP);
            default: w_ready = 1'b0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_csb    <= 1'b1;
            r_sclk   <= 1'b0;
            r_mosi   <= 1'b0;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_shift  <= w_shift_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_csb    <= w_csb;
            r_sclk   <= w_sclk;
            r_mosi   <= w_mosi;
            r_ready  <= w_ready;
            r_busy   <= ~w_ready;
            r_done   <= w_done;
        end
    end

    assign o_ready = r_ready;
    assign o_busy  = r_busy;
    assign o_csb   = r_csb;
    assign o_sclk  = r_sclk;
    assign o_mosi  = r_mosi;
    assign o_done  = r_done;

endmodule

// File: tb/tb_la_spi_cmd_master.sv
module tb_la_spi_cmd_master;

    typedef struct {
        logic [31:0] word;
        int          bits;
    } word_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // DUT with CLK_DIV=2
    logic        rst2 = 1'b1, v2 = 1'b0;
    logic [31:0] data2 = '0;
    logic [5:0]  len2 = '0;
    logic        rdy2, csb2, sclk2, mosi2, busy2, done2;

    // DUT with CLK_DIV=1
    logic        rst1 = 1'b1, v1 = 1'b0;
    logic [31:0] data1 = '0;
    logic [5:0]  len1 = '0;
    logic        rdy1, csb1, sclk1, mosi1, busy1, done1;

    la_spi_cmd_master #(.MAX_BITS(32), .LEN_W(6), .CLK_DIV(2)) u_dut2 (
        .wb_clk_i(clk), .wb_rst_i(rst2), .i_valid(v2), .o_ready(rdy2),
        .i_data(data2), .i_len(len2), .o_csb(csb2), .o_sclk(sclk2),
        .o_mosi(mosi2), .o_busy(busy2), .o_done(done2));

    la_spi_cmd_master #(.MAX_BITS(32), .LEN_W(6), .CLK_DIV(1)) u_dut1 (
        .wb_clk_i(clk), .wb_rst_i(rst1), .i_valid(v1), .o_ready(rdy1),
        .i_data(data1), .i_len(len1), .o_csb(csb1), .o_sclk(sclk1),
        .o_mosi(mosi1), .o_busy(busy1), .o_done(done1));

    // Scoreboards: expected pushed at request time, observed pushed by the slave models.
    word_t exp_q2[$], obs_q2[$], exp_q1[$], obs_q1[$];
    int    rise_q2[$], rise_q1[$], done_q1[$], rdy_q1[$], csbfall_q1[$];
    int    done_cnt2 = 0, done_t2 = 0, rdy_t2 = 0, stab_err2 = 0;
    int    done_cnt1 = 0, stab_err1 = 0;

    // Event times are recorded as "cycle in which the new value is first sampled".
    logic        p_sclk2 = 0, p_csb2 = 1, p_mosi2 = 0, p_rdy2 = 1;
    logic [31:0] acc2 = '0;
    int          nbit2 = 0;
    always @(negedge clk) begin
        if (!csb2 && sclk2 && !p_sclk2) begin
            rise_q2.push_back(cyc + 1);
            acc2  = {acc2[30:0], mosi2};
            nbit2 = nbit2 + 1;
        end
        if (sclk2 && p_sclk2 && (mosi2 !== p_mosi2)) stab_err2 = stab_err2 + 1;
        if (!csb2 && p_csb2) begin
            acc2  = '0;
            nbit2 = 0;
        end
        if (csb2 && !p_csb2) obs_q2.push_back('{word: acc2, bits: nbit2});
        if (done2) begin
            done_cnt2 = done_cnt2 + 1;
            done_t2   = cyc + 1;
        end
        if (rdy2 && !p_rdy2) rdy_t2 = cyc + 1;
        p_sclk2 = sclk2; p_csb2 = csb2; p_mosi2 = mosi2; p_rdy2 = rdy2;
    end

    logic        p_sclk1 = 0, p_csb1 = 1, p_mosi1 = 0, p_rdy1 = 1;
    logic [31:0] acc1 = '0;
    int          nbit1 = 0;
    always @(negedge clk) begin
        if (!csb1 && sclk1 && !p_sclk1) begin
            rise_q1.push_back(cyc + 1);
            acc1  = {acc1[30:0], mosi1};
            nbit1 = nbit1 + 1;
        end
        if (sclk1 && p_sclk1 && (mosi1 !== p_mosi1)) stab_err1 = stab_err1 + 1;
        if (!csb1 && p_csb1) begin
            acc1  = '0;
            nbit1 = 0;
            csbfall_q1.push_back(cyc + 1);
        end
        if (csb1 && !p_csb1) obs_q1.push_back('{word: acc1, bits: nbit1});
        if (done1) begin
            done_cnt1 = done_cnt1 + 1;
            done_q1.push_back(cyc + 1);
        end
        if (rdy1 && !p_rdy1) rdy_q1.push_back(cyc + 1);
        p_sclk1 = sclk1; p_csb1 = csb1; p_mosi1 = mosi1; p_rdy1 = rdy1;
    end

    function automatic word_t mk_exp(input logic [31:0] d, input int l);
        word_t e;
        int    n;
        n = (l == 0 || l > 32) ? 32 : l;
        e.bits = n;
        e.word = (n == 32) ? d : (d & ((32'h1 << n) - 32'h1));
        return e;
    endfunction

    task automatic nstep();
        @(negedge clk);
        #1;
    endtask

    task automatic send2(input logic [31:0] d, input logic [5:0] l,
                         output int t, output bit ok);
        ok = 1'b0;
        t  = 0;
        for (int i = 0; i < 200; i++) begin
            if (rdy2) begin
                ok = 1'b1;
                break;
            end
            nstep();
        end
        if (!ok) return;
        data2 = d; len2 = l; v2 = 1'b1;
        exp_q2.push_back(mk_exp(d, int'(l)));
        @(posedge clk);
        #1;
        t  = cyc;
        v2 = 1'b0;
    endtask

    task automatic wait_done2(input int n0, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            nstep();
            if (done_cnt2 > n0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_ready2(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            nstep();
            if (rdy2) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst1 = 1'b1; rst2 = 1'b1; v1 = 1'b0; v2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({csb2, sclk2, mosi2, rdy2, busy2, done2} !== 6'b100100) begin
            fails++;
            $display("FAIL reset_in_rst2: got %b want 100100", {csb2, sclk2, mosi2, rdy2, busy2, done2});
        end
        rst1 = 1'b0; rst2 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            nstep();
            tests++;
            if ({csb2, sclk2, mosi2, rdy2, busy2, done2} !== 6'b100100) begin
                fails++;
                $display("FAIL reset_idle2 cycle %0d: got %b want 100100", i, {csb2, sclk2, mosi2, rdy2, busy2, done2});
            end
        end
        tests++;
        if ({csb1, sclk1, mosi1, rdy1, busy1, done1} !== 6'b100100) begin
            fails++;
            $display("FAIL reset_idle1: got %b want 100100", {csb1, sclk1, mosi1, rdy1, busy1, done1});
        end
    endtask

    task automatic test_a5();
        int    t, n0;
        bit    ok;
        word_t o, e;
        rise_q2.delete();
        n0 = done_cnt2;
        send2(32'h0000_00A5, 6'd8, t, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL a5_accept: ready never seen"); end
        wait_done2(n0, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL a5_done_timeout: no done"); end
        wait_ready2(ok);
        tests++;
        if (rise_q2.size() != 8) begin
            fails++;
            $display("FAIL a5_rise_count: got %0d want 8", rise_q2.size());
        end else begin
            for (int k = 1; k <= 8; k++) begin
                tests++;
                if (rise_q2[k-1] - t !== 3 + 4 * (k - 1)) begin
                    fails++;
                    $display("FAIL a5_rise%0d: got t+%0d want t+%0d", k, rise_q2[k-1] - t, 3 + 4 * (k - 1));
                end
            end
        end
        tests++;
        if (done_t2 - t !== 35) begin fails++; $display("FAIL a5_done_time: got t+%0d want t+35", done_t2 - t); end
        tests++;
        if (rdy_t2 - t !== 37) begin fails++; $display("FAIL a5_ready_time: got t+%0d want t+37", rdy_t2 - t); end
        tests++;
        if (obs_q2.size() == 0 || exp_q2.size() == 0) begin
            fails++;
            $display("FAIL a5_word: got %0d observed want 1", obs_q2.size());
        end else begin
            o = obs_q2.pop_front();
            e = exp_q2.pop_front();
            if (o.word !== e.word || o.bits !== e.bits) begin
                fails++;
                $display("FAIL a5_word: got %h/%0d want %h/%0d", o.word, o.bits, e.word, e.bits);
            end
        end
    endtask

    task automatic test_len_limits();
        int    t, n0, dur[2];
        bit    ok;
        word_t o, e;
        logic [5:0] lens[2];
        lens[0] = 6'd0;
        lens[1] = 6'd40;
        for (int j = 0; j < 2; j++) begin
            rise_q2.delete();
            n0 = done_cnt2;
            send2(32'h8000_0001, lens[j], t, ok);
            wait_done2(n0, ok);
            tests++;
            if (!ok) begin fails++; $display("FAIL len%0d_done_timeout: no done", lens[j]); end
            dur[j] = done_t2 - t;
            wait_ready2(ok);
            tests++;
            if (rise_q2.size() != 32) begin
                fails++;
                $display("FAIL len%0d_pulses: got %0d want 32", lens[j], rise_q2.size());
            end
            tests++;
            if (obs_q2.size() == 0 || exp_q2.size() == 0) begin
                fails++;
                $display("FAIL len%0d_word: got %0d observed want 1", lens[j], obs_q2.size());
            end else begin
                o = obs_q2.pop_front();
                e = exp_q2.pop_front();
                if (o.word !== e.word || o.bits !== e.bits) begin
                    fails++;
                    $display("FAIL len%0d_word: got %h/%0d want %h/%0d", lens[j], o.word, o.bits, e.word, e.bits);
                end
            end
            tests++;
            if (dur[j] !== 1 + 2 * 65) begin
                fails++;
                $display("FAIL len%0d_done_time: got t+%0d want t+131", lens[j], dur[j]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int    t;
        bit    ok;
        word_t o, e;
        rise_q1.delete(); done_q1.delete(); rdy_q1.delete(); csbfall_q1.delete();
        data1 = 32'h1; len1 = 6'd1;
        exp_q1.push_back(mk_exp(32'h1, 1));
        exp_q1.push_back(mk_exp(32'h1, 1));
        @(negedge clk);
        v1 = 1'b1;
        @(posedge clk);
        #1;
        t = cyc;
        repeat (5) @(posedge clk);
        #1;
        v1 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            nstep();
            if (done_cnt1 >= 2 && rdy1) begin ok = 1'b1; break; end
        end
        tests++;
        if (!ok) begin fails++; $display("FAIL b2b_timeout: got %0d dones want 2", done_cnt1); end
        tests++;
        if (done_q1.size() != 2 || done_q1[0] - t !== 4 || done_q1[1] - t !== 9) begin
            fails++;
            $display("FAIL b2b_done_times: got %0d dones first t+%0d want t+4,t+9",
                     done_q1.size(), (done_q1.size() > 0) ? done_q1[0] - t : -1);
        end
        tests++;
        if (rdy_q1.size() < 1 || rdy_q1[0] - t !== 5) begin
            fails++;
            $display("FAIL b2b_ready_time: got t+%0d want t+5", (rdy_q1.size() > 0) ? rdy_q1[0] - t : -1);
        end
        tests++;
        if (csbfall_q1.size() != 2 || csbfall_q1[1] - t !== 6) begin
            fails++;
            $display("FAIL b2b_second_csb: got %0d falls want second at t+6", csbfall_q1.size());
        end
        tests++;
        if (rise_q1.size() != 2 || rise_q1[0] - t !== 2 || rise_q1[1] - t !== 7) begin
            fails++;
            $display("FAIL b2b_sclk: got %0d rises want t+2,t+7", rise_q1.size());
        end
        for (int j = 0; j < 2; j++) begin
            tests++;
            if (obs_q1.size() == 0 || exp_q1.size() == 0) begin
                fails++;
                $display("FAIL b2b_word%0d: got none want one", j);
            end else begin
                o = obs_q1.pop_front();
                e = exp_q1.pop_front();
                if (o.word !== e.word || o.bits !== e.bits) begin
                    fails++;
                    $display("FAIL b2b_word%0d: got %h/%0d want %h/%0d", j, o.word, o.bits, e.word, e.bits);
                end
            end
        end
    endtask

    task automatic test_ignore_busy();
        int    t, n0;
        bit    ok;
        word_t o, e;
        n0 = done_cnt2;
        send2(32'h0000_005A, 6'd8, t, ok);
        repeat (6) nstep();
        data2 = 32'h0000_003C; len2 = 6'd8; v2 = 1'b1;
        repeat (10) nstep();
        v2 = 1'b0;
        wait_done2(n0, ok);
        wait_ready2(ok);
        repeat (10) nstep();
        tests++;
        if (done_cnt2 - n0 !== 1) begin
            fails++;
            $display("FAIL ignore_done_count: got %0d want 1", done_cnt2 - n0);
        end
        tests++;
        if (obs_q2.size() != 1 || exp_q2.size() != 1) begin
            fails++;
            $display("FAIL ignore_word_count: got %0d want 1", obs_q2.size());
            obs_q2.delete();
            exp_q2.delete();
        end else begin
            o = obs_q2.pop_front();
            e = exp_q2.pop_front();
            if (o.word !== e.word || o.bits !== e.bits) begin
                fails++;
                $display("FAIL ignore_word: got %h/%0d want %h/%0d", o.word, o.bits, e.word, e.bits);
            end
        end
    endtask

    task automatic test_reset_abort();
        int    t, n0;
        bit    ok;
        word_t o, e;
        rise_q2.delete();
        n0 = done_cnt2;
        send2(32'h0000_BEEF, 6'd16, t, ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            nstep();
            if (rise_q2.size() >= 3) begin ok = 1'b1; break; end
        end
        tests++;
        if (!ok) begin fails++; $display("FAIL abort_bits_timeout: got %0d rises want 3", rise_q2.size()); end
        rst2 = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if ({csb2, sclk2, mosi2, rdy2, done2} !== 5'b10010) begin
            fails++;
            $display("FAIL abort_outputs: got %b want 10010", {csb2, sclk2, mosi2, rdy2, done2});
        end
        rst2 = 1'b0;
        repeat (10) nstep();
        tests++;
        if (done_cnt2 !== n0) begin
            fails++;
            $display("FAIL abort_no_done: got %0d dones want 0", done_cnt2 - n0);
        end
        obs_q2.delete();
        exp_q2.delete();
        n0 = done_cnt2;
        send2(32'h0000_1357, 6'd16, t, ok);
        wait_done2(n0, ok);
        wait_ready2(ok);
        tests++;
        if (obs_q2.size() == 0 || exp_q2.size() == 0) begin
            fails++;
            $display("FAIL abort_fresh_word: got none want one");
        end else begin
            o = obs_q2.pop_front();
            e = exp_q2.pop_front();
            if (o.word !== e.word || o.bits !== e.bits) begin
                fails++;
                $display("FAIL abort_fresh_word: got %h/%0d want %h/%0d", o.word, o.bits, e.word, e.bits);
            end
        end
    endtask

    task automatic test_mosi_stable();
        tests++;
        if (stab_err2 !== 0 || stab_err1 !== 0) begin
            fails++;
            $display("FAIL mosi_stable: got %0d/%0d changes while sclk high want 0", stab_err2, stab_err1);
        end
    endtask

    initial begin
        test_reset();
        test_a5();
        test_len_limits();
        test_back_to_back();
        test_ignore_busy();
        test_reset_abort();
        test_mosi_stable();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
